// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I-cache
// miss path and the D-cache miss/writeback path of the LC-3b pipeline.
module lc3b_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy,
    output logic                  owner_d,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_TURN    = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    req_i_s;
    logic                    req_d_s;
    logic                    grant_i_s;
    logic                    grant_d_s;
    logic                    last_d_r;
    logic                    pmem_read_r;
    logic                    pmem_write_r;
    logic [ADDR_WIDTH-1:0]   pmem_address_r;
    logic [LINE_WIDTH-1:0]   pmem_wdata_r;
    logic                    busy_r;
    logic                    proto_err_r;

    assign req_i_s = icache_read;
    assign req_d_s = dcache_read | dcache_write;

    // Next-state and grant decode; on a conflict the side not served last wins.
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_i_s && req_d_s) begin
                    if (last_d_r) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (req_i_s) begin
                    grant_i_s = 1'b1;
                end else if (req_d_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
                if (grant_i_s) begin
                    state_next_s = ST_SERVE_I;
                end else if (grant_d_s) begin
                    state_next_s = ST_SERVE_D;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (pmem_resp) begin
                    state_next_s = ST_TURN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_TURN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory-port request registers, ownership history and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= {ADDR_WIDTH{1'b0}};
            pmem_wdata_r   <= {LINE_WIDTH{1'b0}};
            last_d_r       <= 1'b0;
            busy_r         <= 1'b0;
            proto_err_r    <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (grant_i_s) begin
                pmem_address_r <= icache_address;
                pmem_read_r    <= 1'b1;
                pmem_write_r   <= 1'b0;
                last_d_r       <= 1'b0;
            end else if (grant_d_s) begin
                // Read+write together is a client bug; the writeback wins so dirty data is not lost.
                pmem_address_r <= dcache_address;
                pmem_wdata_r   <= dcache_wdata;
                pmem_read_r    <= ~dcache_write;
                pmem_write_r   <= dcache_write;
                last_d_r       <= 1'b1;
                proto_err_r    <= proto_err_r | (dcache_read & dcache_write);
            end else if (((state_r == ST_SERVE_I) || (state_r == ST_SERVE_D)) && pmem_resp) begin
                pmem_read_r  <= 1'b0;
                pmem_write_r <= 1'b0;
            end else begin
                pmem_read_r  <= pmem_read_r;
                pmem_write_r <= pmem_write_r;
            end
        end
    end

    assign icache_resp  = (state_r == ST_SERVE_I) & pmem_resp;
    assign dcache_resp  = (state_r == ST_SERVE_D) & pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = pmem_address_r;
    assign pmem_wdata   = pmem_wdata_r;
    assign busy         = busy_r;
    assign owner_d      = last_d_r;
    assign proto_err    = proto_err_r;

endmodule
